calc_controller: RTL and testbench



---
 rtl/calc_pkg.sv | 29 ++
 rtl/calc_key_filter.sv | 42 ++++
 rtl/calc_controller.sv | 157 +++++++++++++++
 tb/tb_calc_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared token codes, FSM state encoding and decimal range helper for the
// PS/2 calculator controller.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_EQ  = 4'hC;
  localparam logic [3:0] KEY_ESC = 4'hD;
  localparam logic [3:0] KEY_BRK = 4'hE;
  localparam logic [3:0] KEY_INV = 4'hF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OPA    = 3'd1,
    OP     = 3'd2,
    OPB    = 3'd3,
    RESULT = 3'd4,
    ERROR  = 3'd5
  } calc_state_t;

  // Largest value representable with the given number of decimal digits.
  function automatic int calc_max(input int digits);
    int m;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return m - 1;
  endfunction

endpackage

// File: rtl/calc_key_filter.sv
// Strips PS/2 release (break + following byte) and typematic repeats from the
// decoded token stream; passes the surviving make codes through combinationally.
module calc_key_filter
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       tok_valid,
  output logic [3:0] tok
);

  logic skip;
  logic held;

  // tok_valid is a single-cycle strobe qualified by key_valid; there is no
  // ready, the consumer must take the token in the cycle it is presented.
  always_comb begin
    tok       = key_code;
    tok_valid = key_valid && !skip && !held &&
                (key_code != KEY_INV) && (key_code != KEY_BRK);
  end

  // An invalid token is checked first so an E0 prefix never consumes skip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip <= 1'b0;
      held <= 1'b0;
    end else if (key_valid && (key_code != KEY_INV)) begin
      if (skip) begin
        skip <= 1'b0;
        held <= 1'b0;
      end else if (key_code == KEY_BRK) begin
        skip <= 1'b1;
      end else begin
        held <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_controller.sv
// Entry/operator/result sequencer for the PS/2 calculator: filters key tokens,
// accumulates decimal operands, performs bounded add/subtract, drives display.
module calc_controller
  import calc_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int VALUE_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      key_valid,
  input  logic [3:0]                key_code,
  output logic signed [VALUE_W-1:0] disp_value,
  output logic                      op_active,
  output logic                      op_sub,
  output logic                      err
);

  localparam int MAX = calc_max(DIGITS);
  localparam int EW  = VALUE_W + 4;
  localparam logic signed [EW-1:0]  MAX_EW = EW'(MAX);
  localparam logic signed [VALUE_W:0] MAX_W1 = (VALUE_W + 1)'(MAX);

  logic       tok_valid;
  logic [3:0] tok;

  calc_key_filter u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .tok_valid (tok_valid),
    .tok       (tok)
  );

  calc_state_t               state_q, state_d;
  logic signed [VALUE_W-1:0] a_q, a_d;
  logic        [VALUE_W-1:0] b_q, b_d;
  logic                      op_q, op_d;

  logic signed [VALUE_W-1:0] disp_d;
  logic                      op_active_d, op_sub_d, err_d;

  logic                      is_digit, is_op;
  logic        [VALUE_W-1:0] digit;
  logic signed [EW-1:0]      a_e, b_e, dig_e, a_acc, b_acc;
  logic signed [VALUE_W:0]   r;
  logic                      r_bad;

  // Operands are widened so the x10 step cannot wrap before the range check.
  always_comb begin
    is_digit = (tok < 4'd10);
    is_op    = (tok == KEY_ADD) || (tok == KEY_SUB);
    digit    = {{(VALUE_W-4){1'b0}}, tok};
    a_e      = signed'({{4{a_q[VALUE_W-1]}}, a_q});
    b_e      = signed'({4'b0000, b_q});
    dig_e    = signed'({{(EW-4){1'b0}}, tok});
    a_acc    = (a_e <<< 3) + (a_e <<< 1) + dig_e;
    b_acc    = (b_e <<< 3) + (b_e <<< 1) + dig_e;
    r        = op_q ? (signed'({a_q[VALUE_W-1], a_q}) - signed'({1'b0, b_q}))
                    : (signed'({a_q[VALUE_W-1], a_q}) + signed'({1'b0, b_q}));
    r_bad    = (r > MAX_W1) || (r < -MAX_W1);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    if (tok_valid) begin
      if (tok == KEY_ESC) begin
        state_d = IDLE;
        a_d     = '0;
        b_d     = '0;
        op_d    = 1'b0;
      end else begin
        case (state_q)
          IDLE, RESULT: begin
            if (is_digit) begin
              a_d     = digit;
              state_d = OPA;
            end else if (is_op) begin
              if (state_q == IDLE) a_d = '0;
              op_d    = (tok == KEY_SUB);
              state_d = OP;
            end
          end
          OPA: begin
            if (is_digit) begin
              if (a_acc <= MAX_EW) a_d = a_acc[VALUE_W-1:0];
            end else if (is_op) begin
              op_d    = (tok == KEY_SUB);
              state_d = OP;
            end
          end
          OP: begin
            if (is_digit) begin
              b_d     = digit;
              state_d = OPB;
            end else if (is_op) begin
              op_d = (tok == KEY_SUB);
            end
          end
          OPB: begin
            if (is_digit) begin
              if (b_acc <= MAX_EW) b_d = b_acc[VALUE_W-1:0];
            end else if (is_op || (tok == KEY_EQ)) begin
              if (r_bad) begin
                state_d = ERROR;
              end else begin
                a_d     = r[VALUE_W-1:0];
                state_d = is_op ? OP : RESULT;
                if (is_op) op_d = (tok == KEY_SUB);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs are derived from next-state values so they register in the same edge.
  always_comb begin
    op_active_d = (state_d == OP) || (state_d == OPB);
    op_sub_d    = op_active_d && op_d;
    err_d       = (state_d == ERROR);
    case (state_d)
      ERROR:   disp_d = '0;
      OPB:     disp_d = signed'(b_d);
      default: disp_d = a_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      disp_value <= '0;
      op_active  <= 1'b0;
      op_sub     <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      disp_value <= disp_d;
      op_active  <= op_active_d;
      op_sub     <= op_sub_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench for calc_controller: directed key sequences plus random
// keystrokes, compared against an integer-level calculator model.
module tb_calc_controller;

  localparam int VALUE_W = 16;
  localparam int MAXV    = 9999;
  localparam int W       = VALUE_W + 3;

  localparam int M_IDLE = 0, M_ENTA = 1, M_OPER = 2, M_ENTB = 3, M_RES = 4, M_ERR = 5;

  logic                      clk;
  logic                      rst_n;
  logic                      key_valid;
  logic [3:0]                key_code;
  logic signed [VALUE_W-1:0] disp_value;
  logic                      op_active;
  logic                      op_sub;
  logic                      err;

  calc_controller #(.DIGITS(4), .VALUE_W(VALUE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .disp_value (disp_value),
    .op_active  (op_active),
    .op_sub     (op_sub),
    .err        (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // reference model: calculator seen as integers and a mode number
  int m_a, m_b, m_mode;
  bit m_sub, m_skip, m_held;

  function automatic void model_reset();
    m_a = 0; m_b = 0; m_mode = M_IDLE; m_sub = 0; m_skip = 0; m_held = 0;
  endfunction

  function automatic void model_token(int c);
    int r;
    if (c == 13) begin
      m_a = 0; m_b = 0; m_sub = 0; m_mode = M_IDLE;
      return;
    end
    if (m_mode == M_ERR) return;
    if (c <= 9) begin
      case (m_mode)
        M_IDLE, M_RES: begin m_a = c; m_mode = M_ENTA; end
        M_ENTA: if (m_a * 10 + c <= MAXV) m_a = m_a * 10 + c;
        M_OPER: begin m_b = c; m_mode = M_ENTB; end
        M_ENTB: if (m_b * 10 + c <= MAXV) m_b = m_b * 10 + c;
        default: ;
      endcase
    end else if (c == 10 || c == 11) begin
      if (m_mode == M_ENTB) begin
        r = m_sub ? m_a - m_b : m_a + m_b;
        if (r > MAXV || r < -MAXV) begin m_mode = M_ERR; return; end
        m_a = r;
      end else if (m_mode == M_IDLE) begin
        m_a = 0;
      end
      m_sub = (c == 11);
      m_mode = M_OPER;
    end else if (c == 12 && m_mode == M_ENTB) begin
      r = m_sub ? m_a - m_b : m_a + m_b;
      if (r > MAXV || r < -MAXV) m_mode = M_ERR;
      else begin m_a = r; m_mode = M_RES; end
    end
  endfunction

  function automatic void model_byte(int c);
    if (c == 15) return;
    if (m_skip) begin m_skip = 0; m_held = 0; return; end
    if (c == 14) begin m_skip = 1; return; end
    if (m_held) return;
    m_held = 1;
    model_token(c);
  endfunction

  function automatic logic [W-1:0] model_out();
    int  d;
    bit  act;
    d   = (m_mode == M_ERR) ? 0 : (m_mode == M_ENTB) ? m_b : m_a;
    act = (m_mode == M_OPER) || (m_mode == M_ENTB);
    return {VALUE_W'(d), act, act && m_sub, m_mode == M_ERR};
  endfunction

  // driver tasks
  task automatic send(input int c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'(c);
    model_byte(c);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic press(input int c);
    send(c); send(14); send(c);
  endtask

  task automatic check_out(input string name, input int e_disp, input bit e_act,
                           input bit e_sub, input bit e_err);
    total++;
    if (disp_value !== VALUE_W'(e_disp) || op_active !== e_act ||
        op_sub !== e_sub || err !== e_err) begin
      bad++;
      $display("FAIL %s: got disp=%0d act=%0b sub=%0b err=%0b, want disp=%0d act=%0b sub=%0b err=%0b",
               name, disp_value, op_active, op_sub, err, e_disp, e_act, e_sub, e_err);
    end
  endtask

  // scoreboard monitor: every byte presented at an edge is checked just after it
  always @(posedge clk) begin
    logic         kv;
    logic [W-1:0] exp_v, got_v;
    kv = key_valid;
    #1;
    if (kv) begin
      total++;
      got_v = {disp_value, op_active, op_sub, err};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: got disp=%0d with no expected entry", disp_value);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          bad++;
          $display("FAIL sb_byte: got disp=%0d act=%0b sub=%0b err=%0b, want disp=%0d act=%0b sub=%0b err=%0b",
                   $signed(got_v[W-1:3]), got_v[2], got_v[1], got_v[0],
                   $signed(exp_v[W-1:3]), exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    int r, c;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    model_reset();
    idle(3);
    check_out("reset_state", 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(1);

    // release bytes and typematic repeat are dropped
    send(1); send(14); send(1); send(2); send(2); send(14); send(2);
    idle(2);
    check_out("filter_12", 12, 0, 0, 0);
    press(13); idle(1);

    // add, then reuse of the result
    press(1); press(2); press(3); press(10); press(4); press(5); press(12);
    idle(1);
    check_out("add_168", 168, 0, 0, 0);
    press(10); press(2); press(12);
    idle(1);
    check_out("reuse_170", 170, 0, 0, 0);
    press(13); idle(1);

    // subtract to negative, then chaining
    press(3); press(11); press(1); press(0);
    idle(1);
    check_out("sub_pending", 10, 1, 1, 0);
    press(12);
    idle(1);
    check_out("sub_neg7", -7, 0, 0, 0);
    press(11); press(5); press(11);
    idle(1);
    check_out("chain_neg12", -12, 1, 1, 0);
    press(13); idle(1);

    // saturation of entry, overflow into error, recovery by esc
    for (int i = 0; i < 5; i++) press(9);
    idle(1);
    check_out("sat_9999", 9999, 0, 0, 0);
    press(10); press(1); press(12);
    idle(1);
    check_out("overflow_err", 0, 0, 0, 1);
    press(4); press(12); press(10);
    idle(1);
    check_out("err_hold", 0, 0, 0, 1);
    press(13);
    idle(1);
    check_out("esc_clear", 0, 0, 0, 0);

    // tokens with no effect in IDLE, then operator replacement
    send(15); send(15); send(14); send(3); press(12);
    idle(1);
    check_out("idle_ignored", 0, 0, 0, 0);
    press(10); press(11); press(11); press(7); press(12);
    idle(1);
    check_out("replace_neg7", -7, 0, 0, 0);
    press(13);

    // esc right after a break is a release byte and is dropped
    press(6); send(14); send(13);
    idle(1);
    check_out("esc_after_brk", 6, 0, 0, 0);
    press(13);

    // asynchronous reset mid-entry with a key held
    press(4); send(5);
    idle(1);
    check_out("pre_reset_45", 45, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_out("async_reset", 0, 0, 0, 0);
    model_reset();
    idle(1);
    rst_n = 1'b1;
    send(6);
    idle(1);
    check_out("after_reset_6", 6, 0, 0, 0);

    // random keystrokes
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 12) begin
        send($urandom_range(0, 15));
      end else begin
        r = $urandom_range(0, 99);
        if (r < 70)      c = $urandom_range(0, 9);
        else if (r < 85) c = $urandom_range(10, 11);
        else if (r < 95) c = 12;
        else             c = 13;
        press(c);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d entries left, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
